// File: rtl/selecao_bebida_param_if.sv
// Front-panel / sequencer bundle for the beverage-selection controller.
// master = panel + downstream side (drives buttons, reads status),
// slave  = the controller itself.
interface selecao_bebida_param_if #(
  parameter int SEL_W = 2
);
  logic             Inicia;
  logic [SEL_W-1:0] Sel;
  logic             Confirma;
  logic             Cancela;
  logic             Libera;
  logic [1:0]       SAIDA;
  logic [SEL_W:0]   SAIDA_DISPLAY;
  logic [SEL_W-1:0] Escolha;
  logic             Valido;

  modport master (
    output Inicia, Sel, Confirma, Cancela, Libera,
    input  SAIDA, SAIDA_DISPLAY, Escolha, Valido
  );

  modport slave (
    input  Inicia, Sel, Confirma, Cancela, Libera,
    output SAIDA, SAIDA_DISPLAY, Escolha, Valido
  );
endinterface

// File: rtl/selecao_bebida_param.sv
// Parametrised beverage-selection controller. Moore FSM with an internal
// timeout counter; every output is registered and takes the value of the
// state being entered on the same edge as the transition.
module selecao_bebida_param #(
  parameter int N_OPCOES       = 4,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                    CLK,
  input  logic                    RST,
  selecao_bebida_param_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    ANALISE,
    SELECIONADO,
    ESCOLHEU,
    NAO_ESCOLHEU
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       saida_q, saida_d;
  logic [SEL_W:0]   display_q, display_d;
  logic [SEL_W-1:0] escolha_q, escolha_d;
  logic             valido_q, valido_d;

  logic sel_ok;
  logic cnt_max;

  // Codes at or above N_OPCOES are treated as "nothing selected".
  assign sel_ok  = ({1'b0, bus.Sel} < (SEL_W+1)'(N_OPCOES));
  assign cnt_max = (cnt_q == CNT_MAX);

  // Next-state, counter, latched index and the outputs of the entered state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    escolha_d = escolha_q;
    valido_d  = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (bus.Inicia) begin
          state_d = ANALISE;
          cnt_d   = '0;
        end
      end
      ANALISE: begin
        // Confirma has no meaning yet: nothing is selected.
        if (bus.Cancela) begin
          state_d = NAO_ESCOLHEU;
        end else if (sel_ok) begin
          state_d = SELECIONADO;
          idx_d   = bus.Sel;
          cnt_d   = '0;
        end else if (cnt_max) begin
          state_d = NAO_ESCOLHEU;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SELECIONADO: begin
        // Confirma wins over a same-edge selection change: the held idx is used.
        if (bus.Cancela) begin
          state_d = NAO_ESCOLHEU;
        end else if (bus.Confirma) begin
          state_d   = ESCOLHEU;
          escolha_d = idx_q;
          valido_d  = 1'b1;
        end else if (sel_ok && (bus.Sel != idx_q)) begin
          idx_d = bus.Sel;
          cnt_d = '0;
        end else if (cnt_max) begin
          state_d   = ESCOLHEU;
          escolha_d = idx_q;
          valido_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ESCOLHEU, NAO_ESCOLHEU: begin
        // Inicia on the same edge is deliberately not honoured here.
        if (bus.Libera) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase

    saida_d   = 2'b00;
    display_d = '0;
    case (state_d)
      SELECIONADO: begin
        saida_d   = 2'b01;
        display_d = (SEL_W+1)'(idx_d) + (SEL_W+1)'(1);
      end
      ESCOLHEU: begin
        saida_d   = 2'b11;
        display_d = (SEL_W+1)'(idx_d) + (SEL_W+1)'(1);
      end
      NAO_ESCOLHEU: saida_d = 2'b10;
      default: ;
    endcase
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= OCIOSO;
      idx_q     <= '0;
      cnt_q     <= '0;
      saida_q   <= 2'b00;
      display_q <= '0;
      escolha_q <= '0;
      valido_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      saida_q   <= saida_d;
      display_q <= display_d;
      escolha_q <= escolha_d;
      valido_q  <= valido_d;
    end
  end

  assign bus.SAIDA         = saida_q;
  assign bus.SAIDA_DISPLAY = display_q;
  assign bus.Escolha       = escolha_q;
  assign bus.Valido        = valido_q;

endmodule

// File: tb/tb_selecao_bebida_param.sv
// Scoreboard bench: stimulus pushes the hand-computed expected outputs for
// each edge; a negedge monitor pops and compares them against the DUT.
module tb_selecao_bebida_param;

  logic clk;
  logic rst0, rst1;

  selecao_bebida_param_if #(.SEL_W(2)) b0 ();
  selecao_bebida_param_if #(.SEL_W(2)) b1 ();

  selecao_bebida_param #(.N_OPCOES(4), .SEL_W(2), .TIMEOUT_CICLOS(8)) dut0 (
    .CLK(clk), .RST(rst0), .bus(b0)
  );
  selecao_bebida_param #(.N_OPCOES(3), .SEL_W(2), .TIMEOUT_CICLOS(8)) dut1 (
    .CLK(clk), .RST(rst1), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic [1:0] saida;
    logic [2:0] disp;
    logic [1:0] esc;
    logic       val;
    int         id;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_id   = 0;

  // Drive one cycle of inputs on dut d, idle the other, and queue the
  // outputs expected right after the coming rising edge.
  task automatic drv(input int d, input bit ini, input logic [1:0] sel,
                     input bit cf, input bit cn, input bit lb, input bit rs,
                     input logic [1:0] es, input logic [2:0] ed,
                     input logic [1:0] ee, input bit ev);
    exp_t e;
    if (d == 0) begin
      b0.Inicia = ini; b0.Sel = sel; b0.Confirma = cf; b0.Cancela = cn;
      b0.Libera = lb; rst0 = rs;
      b1.Inicia = 0; b1.Sel = 0; b1.Confirma = 0; b1.Cancela = 0; b1.Libera = 0;
    end else begin
      b1.Inicia = ini; b1.Sel = sel; b1.Confirma = cf; b1.Cancela = cn;
      b1.Libera = lb; rst1 = rs;
      b0.Inicia = 0; b0.Sel = 0; b0.Confirma = 0; b0.Cancela = 0; b0.Libera = 0;
    end
    @(posedge clk);
    e.dut = d; e.saida = es; e.disp = ed; e.esc = ee; e.val = ev; e.id = vec_id;
    vec_id++;
    sbq.push_back(e);
    #2;
  endtask

  // Monitor: compares every queued expectation against the sampled outputs.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t       e;
      logic [1:0] a_s;
      logic [2:0] a_d;
      logic [1:0] a_e;
      logic       a_v;
      e = sbq.pop_front();
      if (e.dut == 0) begin
        a_s = b0.SAIDA; a_d = b0.SAIDA_DISPLAY; a_e = b0.Escolha; a_v = b0.Valido;
      end else begin
        a_s = b1.SAIDA; a_d = b1.SAIDA_DISPLAY; a_e = b1.Escolha; a_v = b1.Valido;
      end
      checks++;
      if (a_s !== e.saida || a_d !== e.disp || a_e !== e.esc || a_v !== e.val) begin
        failures++;
        $display("FAIL vec%0d dut%0d: got saida=%b disp=%0d esc=%0d val=%b, want saida=%b disp=%0d esc=%0d val=%b",
                 e.id, e.dut, a_s, a_d, a_e, a_v, e.saida, e.disp, e.esc, e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1; rst1 = 1;
    b0.Inicia = 0; b0.Sel = 0; b0.Confirma = 0; b0.Cancela = 0; b0.Libera = 0;
    b1.Inicia = 0; b1.Sel = 0; b1.Confirma = 0; b1.Cancela = 0; b1.Libera = 0;

    // Basic flow: reset, start, select 2, confirm, release.
    drv(0, 0,0,0,0,0,1, 2'b00,0,0,0);
    drv(0, 1,2,0,0,0,0, 2'b00,0,0,0);
    drv(0, 0,2,0,0,0,0, 2'b01,3,0,0);
    drv(0, 0,2,1,0,0,0, 2'b11,3,2,1);
    drv(0, 0,2,0,0,0,0, 2'b11,3,2,0);
    drv(0, 0,2,0,0,1,0, 2'b00,0,2,0);

    // N=3: invalid code 3 held -> 8 cycles of ANALISE then NAO_ESCOLHEU.
    // Confirma toggled meanwhile must be ignored.
    drv(1, 0,0,0,0,0,1, 2'b00,0,0,0);
    drv(1, 1,3,0,0,0,0, 2'b00,0,0,0);
    for (int i = 0; i < 7; i++) drv(1, 0,3,(i % 2 == 1),0,0,0, 2'b00,0,0,0);
    drv(1, 0,3,0,0,0,0, 2'b10,0,0,0);
    drv(1, 0,3,0,0,1,0, 2'b00,0,0,0);

    // Auto-confirm after timeout with Sel=1 held.
    drv(0, 1,1,0,0,0,0, 2'b00,0,2,0);
    drv(0, 0,1,0,0,0,0, 2'b01,2,2,0);
    for (int i = 0; i < 7; i++) drv(0, 0,1,0,0,0,0, 2'b01,2,2,0);
    drv(0, 0,1,0,0,0,0, 2'b11,2,1,1);
    drv(0, 0,1,0,0,1,0, 2'b00,0,1,0);

    // Selection change 1->0 restarts the counter.
    drv(0, 1,1,0,0,0,0, 2'b00,0,1,0);
    drv(0, 0,1,0,0,0,0, 2'b01,2,1,0);
    for (int i = 0; i < 4; i++) drv(0, 0,1,0,0,0,0, 2'b01,2,1,0);
    drv(0, 0,0,0,0,0,0, 2'b01,1,1,0);
    for (int i = 0; i < 7; i++) drv(0, 0,0,0,0,0,0, 2'b01,1,1,0);
    drv(0, 0,0,0,0,0,0, 2'b11,1,0,1);
    drv(0, 0,0,0,0,1,0, 2'b00,0,0,0);

    // Priority: Confirma beats a same-edge Sel change.
    drv(0, 1,1,0,0,0,0, 2'b00,0,0,0);
    drv(0, 0,1,0,0,0,0, 2'b01,2,0,0);
    drv(0, 0,3,1,0,0,0, 2'b11,2,1,1);
    drv(0, 0,3,0,0,1,0, 2'b00,0,1,0);
    // Cancela beats Confirma.
    drv(0, 1,0,0,0,0,0, 2'b00,0,1,0);
    drv(0, 0,0,0,0,0,0, 2'b01,1,1,0);
    drv(0, 0,0,1,1,0,0, 2'b10,0,1,0);
    drv(0, 0,0,0,0,1,0, 2'b00,0,1,0);

    // Inicia/Libera ignored in SELECIONADO; reset mid-session clears all.
    drv(0, 1,2,0,0,0,0, 2'b00,0,1,0);
    drv(0, 0,2,0,0,0,0, 2'b01,3,1,0);
    drv(0, 1,2,0,0,1,0, 2'b01,3,1,0);
    drv(0, 1,2,0,0,1,0, 2'b01,3,1,0);
    drv(0, 0,2,0,0,0,1, 2'b00,0,0,0);
    drv(0, 0,2,0,0,0,0, 2'b00,0,0,0);

    // Release collision: Libera+Inicia -> OCIOSO only; ANALISE one edge later.
    drv(0, 1,2,0,0,0,0, 2'b00,0,0,0);
    drv(0, 0,2,0,0,0,0, 2'b01,3,0,0);
    drv(0, 0,2,1,0,0,0, 2'b11,3,2,1);
    drv(0, 1,2,0,0,1,0, 2'b00,0,2,0);
    drv(0, 1,2,0,0,0,0, 2'b00,0,2,0);
    drv(0, 0,2,0,0,0,0, 2'b01,3,2,0);
    drv(0, 0,2,0,1,0,0, 2'b10,0,2,0);
    drv(0, 0,2,0,0,1,0, 2'b00,0,2,0);

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
